bcd_serial_alu_ctrl: RTL and testbench



---
 rtl/bcd_serial_alu_ctrl.sv | 145 ++++++++++++++
 tb/tb_bcd_serial_alu_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bcd_serial_alu_ctrl.sv
// Serial packed-BCD add/subtract sequencer: one combinational BCD digit cell,
// reused once per clock from the least-significant digit upward.

module bcd_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [4:0] bin;
  logic [4:0] adj;

  always_comb begin
    bin    = {1'b0, a_i} + {1'b0, b_i} + {4'b0, cin_i};
    adj    = bin + 5'd6;
    cout_o = (bin > 5'd9);
    sum_o  = cout_o ? adj[3:0] : bin[3:0];
  end
endmodule

module bcd_serial_alu_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  sub_i,
  input  logic [4*DIGITS-1:0]   a_i,
  input  logic [4*DIGITS-1:0]   b_i,
  input  logic                  carry_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   sum_o,
  output logic                  carry_o,
  output logic                  err_o
);
  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               sub_q;
  logic [W-1:0]       a_q, b_q;
  logic [W-1:0]       sum_q;
  logic               cout_q;
  logic               err_q;
  logic               done_q;

  logic [3:0]         b_dig;
  logic [3:0]         cell_a, cell_b, cell_sum;
  logic               cell_cout;
  logic               bad_operand;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign bad_operand = has_bad_digit(a_i) | has_bad_digit(b_i);

  // Subtraction runs as A + nines'(B) + ~borrow; final carry is inverted to a borrow.
  always_comb begin
    b_dig  = b_q[idx_q*4 +: 4];
    cell_a = a_q[idx_q*4 +: 4];
    cell_b = sub_q ? (4'd9 - b_dig) : b_dig;
  end

  bcd_adder u_cell (
    .a_i    (cell_a),
    .b_i    (cell_b),
    .cin_i  (carry_q),
    .sum_o  (cell_sum),
    .cout_o (cell_cout)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = bad_operand ? S_DONE : S_RUN;
      S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q != S_IDLE);
    done_o  = done_q;
    sum_o   = sum_q;
    carry_o = cout_q;
    err_o   = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // done lags the DONE state by one edge, so it lands in the following IDLE cycle
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            sub_q   <= sub_i;
            idx_q   <= '0;
            carry_q <= sub_i ? ~carry_i : carry_i;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= bad_operand;
          end
        end
        S_RUN: begin
          sum_q[idx_q*4 +: 4] <= cell_sum;
          carry_q             <= cell_cout;
          idx_q               <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) cout_q <= sub_q ? ~cell_cout : cell_cout;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_alu_ctrl.sv
// Directed bench for bcd_serial_alu_ctrl (DIGITS=4) with hand-computed results.

module tb_bcd_serial_alu_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        sub_i;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        carry_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] sum_o;
  logic        carry_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;
  int lat;
  int busy_n;
  logic saw_done;

  bcd_serial_alu_ctrl #(.DIGITS(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .sub_i   (sub_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .carry_i (carry_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .carry_o (carry_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples 1 time unit after each edge until done_o; lat = edge index where done appeared.
  task automatic wait_done(input int first, output int lat_o, output int busy_cnt);
    lat_o    = first;
    busy_cnt = 0;
    while (!done_o && lat_o < 40) begin
      if (busy_o) busy_cnt++;
      @(posedge clk_i); #1;
      lat_o++;
    end
    chk("done_seen", done_o, 1'b1);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c);
    @(negedge clk_i);
    a_i = a; b_i = b; sub_i = s; carry_i = c; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic c, input logic [15:0] exp_sum,
                        input logic exp_c, input logic exp_err, input int exp_lat);
    start_op(a, b, s, c);
    wait_done(0, lat, busy_n);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_sum"}, sum_o, exp_sum);
    chk({tag, "_carry"}, carry_o, exp_c);
    chk({tag, "_err"}, err_o, exp_err);
    @(posedge clk_i); #1;
    chk({tag, "_done_pulse"}, done_o, 1'b0);
    chk({tag, "_hold_sum"}, sum_o, exp_sum);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; sub_i = 1'b0; a_i = '0; b_i = '0; carry_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_sum", sum_o, 16'h0000);
    chk("rst_carry", carry_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    run_op("add1234", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 5);
    chk("add1234_busy_cycles", busy_n, 5);
    chk("add1234_idle_busy", busy_o, 1'b0);

    run_op("add9999", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 5);
    run_op("add_cin", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 5);
    run_op("sub0500", 16'h0500, 16'h0123, 1'b1, 1'b0, 16'h0377, 1'b0, 1'b0, 5);
    run_op("sub_bin", 16'h0500, 16'h0123, 1'b1, 1'b1, 16'h0376, 1'b0, 1'b0, 5);
    run_op("sub_borrow", 16'h0100, 16'h0200, 1'b1, 1'b0, 16'h9900, 1'b1, 1'b0, 5);
    run_op("sub_equal", 16'h4321, 16'h4321, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5);
    run_op("bad_a", 16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1);
    chk("bad_a_busy_cycles", busy_n, 1);
    run_op("bad_b", 16'h0001, 16'hF000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1);
    run_op("after_err", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 5);

    // Start pulse and operand changes during RUN must be ignored
    start_op(16'h1234, 16'h5678, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    start_i = 1'b1; a_i = 16'h9999; b_i = 16'h9999; sub_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done(3, lat, busy_n);
    chk("ign_lat", lat, 5);
    chk("ign_sum", sum_o, 16'h6912);
    chk("ign_carry", carry_o, 1'b0);
    @(posedge clk_i); #1;
    chk("ign_no_restart", busy_o, 1'b0);

    // Reset while digit 2 is being processed
    start_op(16'h9876, 16'h1111, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("mid_busy", busy_o, 1'b1);
    chk("mid_partial_sum", sum_o, 16'h0087);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("mrst_busy", busy_o, 1'b0);
    chk("mrst_done", done_o, 1'b0);
    chk("mrst_sum", sum_o, 16'h0000);
    chk("mrst_carry", carry_o, 1'b0);
    chk("mrst_err", err_o, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      saw_done = saw_done | done_o | busy_o;
    end
    chk("mrst_no_done", saw_done, 1'b0);

    run_op("post_rst", 16'h9876, 16'h1111, 1'b0, 1'b0, 16'h0987, 1'b1, 1'b0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
